// File: rtl/bram_fifo_pkg.sv
// Shared constants and helpers for the BRAM-backed FIFO.
package bram_fifo_pkg;

  // Number of words held in the registered output stage in front of the BRAM
  localparam int PREFETCH_DEPTH  = 2;
  // Width of the stall statistics counter
  localparam int STATS_CNT_WIDTH = 32;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [STATS_CNT_WIDTH-1:0] sat_inc(input logic [STATS_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + STATS_CNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/bram_fifo_bram.sv
// Simple dual-port block RAM: port A write, port B read (write capable),
// registered read data with one cycle of latency. Contents are not reset.
module dualport_bram #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  a_we_i,
  input  logic [ADDR_WIDTH-1:0] a_addr_i,
  input  logic [DATA_WIDTH-1:0] a_din_i,
  input  logic                  b_en_i,
  input  logic                  b_we_i,
  input  logic [ADDR_WIDTH-1:0] b_addr_i,
  input  logic [DATA_WIDTH-1:0] b_din_i,
  output logic [DATA_WIDTH-1:0] b_dout_o
);

  (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem_q [0:(1<<ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] b_dout_q;

  // Both ports share one process so the array has a single driver
  always_ff @(posedge clk_i) begin
    if (a_we_i) begin
      mem_q[a_addr_i] <= a_din_i;
    end
    if (b_en_i) begin
      if (b_we_i) begin
        mem_q[b_addr_i] <= b_din_i;
      end
      b_dout_q <= mem_q[b_addr_i];
    end
  end

  assign b_dout_o = b_dout_q;

endmodule

// File: rtl/bram_fifo.sv
// BRAM-backed FIFO with a 2-entry prefetch buffer so the head word is
// always presented from registers and throughput is one word per cycle.
// Optional macro BRAM_FIFO_STATS_EN enables the saturating stall counter;
// without it stall_cnt_o is tied to zero.
module bram_fifo
  import bram_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       s_valid_i,
  input  logic [DATA_WIDTH-1:0]      s_data_i,
  output logic                       s_ready_o,
  output logic                       m_valid_o,
  output logic [DATA_WIDTH-1:0]      m_data_o,
  input  logic                       m_ready_i,
  output logic [ADDR_WIDTH+1:0]      fill_o,
  output logic [STATS_CNT_WIDTH-1:0] stall_cnt_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;
  localparam int FW    = ADDR_WIDTH + 2;

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, occ, occ_d;
  logic                  s_ready_q, s_ready_d;
  logic                  rd_pend_q, rd_pend_d;
  logic [1:0]            pf_cnt_q, pf_cnt_d;
  logic                  pf_head_q, pf_head_d, pf_tail;
  logic [FW-1:0]         fill_q, fill_d;
  logic [DATA_WIDTH-1:0] pf_data_q [PREFETCH_DEPTH];
  logic [DATA_WIDTH-1:0] b_dout;
  logic [2:0]            pf_need;
  logic                  wr_en, rd_en, pop;

  dualport_bram #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_bram (
    .clk_i   (clk_i),
    .a_we_i  (wr_en),
    .a_addr_i(wr_ptr_q[ADDR_WIDTH-1:0]),
    .a_din_i (s_data_i),
    .b_en_i  (rd_en),
    .b_we_i  (1'b0),
    .b_addr_i(rd_ptr_q[ADDR_WIDTH-1:0]),
    .b_din_i ({DATA_WIDTH{1'b0}}),
    .b_dout_o(b_dout)
  );

  // Handshakes, read issue decision and next-state arithmetic
  always_comb begin
    wr_en     = s_valid_i && s_ready_q;
    pop       = (pf_cnt_q != 2'd0) && m_ready_i;
    occ       = wr_ptr_q - rd_ptr_q;
    // Slots the buffer will need after this edge if no new read is issued
    pf_need   = {1'b0, pf_cnt_q} + {2'b00, rd_pend_q} - {2'b00, pop};
    // occ > 0 guarantees the read never targets the slot being written now
    rd_en     = (occ != '0) && (pf_need < 3'(PREFETCH_DEPTH));
    wr_ptr_d  = wr_ptr_q + PW'(wr_en);
    rd_ptr_d  = rd_ptr_q + PW'(rd_en);
    occ_d     = occ + PW'(wr_en) - PW'(rd_en);
    s_ready_d = occ_d < PW'(DEPTH);
    rd_pend_d = rd_en;
    pf_cnt_d  = pf_cnt_q + {1'b0, rd_pend_q} - {1'b0, pop};
    pf_head_d = pf_head_q ^ pop;
    // At capture time the count is at most 1, so the tail is a 1-bit offset
    pf_tail   = pf_head_q ^ pf_cnt_q[0];
    fill_d    = fill_q + FW'(wr_en) - FW'(pop);
  end

  // Control state; reset discards every word, including an in-flight read
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      s_ready_q <= 1'b0;
      rd_pend_q <= 1'b0;
      pf_cnt_q  <= '0;
      pf_head_q <= 1'b0;
      fill_q    <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      s_ready_q <= s_ready_d;
      rd_pend_q <= rd_pend_d;
      pf_cnt_q  <= pf_cnt_d;
      pf_head_q <= pf_head_d;
      fill_q    <= fill_d;
    end
  end

  // Prefetch data capture from the BRAM read port one cycle after issue
  always_ff @(posedge clk_i) begin
    if (rd_pend_q) begin
      pf_data_q[pf_tail] <= b_dout;
    end
  end

  assign s_ready_o = s_ready_q;
  assign m_valid_o = (pf_cnt_q != 2'd0);
  assign m_data_o  = pf_data_q[pf_head_q];
  assign fill_o    = fill_q;

`ifdef BRAM_FIFO_STATS_EN
  logic [STATS_CNT_WIDTH-1:0] stall_cnt_q;

  // Count cycles where upstream offers a word that cannot be taken
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else if (s_valid_i && !s_ready_q) begin
      stall_cnt_q <= sat_inc(stall_cnt_q);
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_bram_fifo.sv
// Bench for bram_fifo: directed scenarios plus randomized traffic, checked
// every cycle against a queue-based model of the FIFO's contents.
module tb_bram_fifo;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int CAP   = DEPTH + 2;

  logic          clk;
  logic          rst;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;
  logic [AW+1:0] fill;
  logic [31:0]   stall_cnt;

  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bram_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .s_valid_i  (s_valid),
    .s_data_i   (s_data),
    .s_ready_o  (s_ready),
    .m_valid_o  (m_valid),
    .m_data_o   (m_data),
    .m_ready_i  (m_ready),
    .fill_o     (fill),
    .stall_cnt_o(stall_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: contents as a queue, updated on each clock edge
  logic [DW-1:0] q[$];
  int            stall_model;
  int            edges_since_rst;
  bit            hold_prev;
  logic [DW-1:0] held_data;
  int            pop_total = 0;
  int            gap = 0;

  initial begin
    stall_model     = 0;
    edges_since_rst = 0;
    hold_prev       = 1'b0;
    held_data       = '0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        q.delete();
        stall_model     = 0;
        edges_since_rst = 0;
        hold_prev       = 1'b0;
      end else begin
        edges_since_rst++;
        if (s_valid && !s_ready) stall_model++;
        if (m_valid && m_ready) begin
          chk("pop_nonempty", (q.size() != 0), 1);
          if (q.size() != 0) void'(q.pop_front());
          pop_total++;
        end
        if (s_valid && s_ready) begin
          chk("push_room", (q.size() < CAP), 1);
          q.push_back(s_data);
        end
        hold_prev = m_valid && !m_ready;
        held_data = m_data;
      end
    end
  end

  // Compare process: DUT outputs against the model on every falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_m_valid", m_valid, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_fill", fill, 0);
        chk("rst_stall", stall_cnt, 0);
        gap = 0;
      end else begin
        chk("fill", fill, q.size());
        if (q.size() == 0) chk("m_valid_empty", m_valid, 0);
        else if (m_valid) chk("m_data_order", m_data, q[0]);
        if (edges_since_rst > 0 && q.size() < DEPTH) chk("s_ready_room", s_ready, 1);
        if (q.size() == CAP) chk("s_ready_full", s_ready, 0);
        if (hold_prev) begin
          chk("hold_valid", m_valid, 1);
          chk("hold_data", m_data, held_data);
        end
        if (q.size() > 0 && !m_valid) gap++;
        else gap = 0;
        chk("head_latency", (gap <= 2), 1);
`ifdef BRAM_FIFO_STATS_EN
        chk("stall_cnt", stall_cnt, stall_model);
`else
        chk("stall_cnt_zero", stall_cnt, 0);
`endif
      end
    end
  end

  // Advance to 2 time units after the next rising edge(s)
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b0;
    s_data  = '0;
    step(3);
    rst = 1'b0;
    #1;
    chk("ready_low_before_edge", s_ready, 0);
    step(1);
    chk("ready_after_first_edge", s_ready, 1);
  endtask

  int base;
  int pv_tbl[8] = '{50, 90, 30, 70, 95, 50, 20, 60};
  int pr_tbl[8] = '{50, 20, 80, 50, 10, 50, 90, 50};

  initial begin
    rst     = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b0;
    s_data  = '0;

    // Single word latency through an empty FIFO
    do_reset();
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_data  = 32'hA5A5_0001;
    step(1);
    s_valid = 1'b0;
    chk("single_valid_k", m_valid, 0);
    chk("single_fill_k", fill, 1);
    step(1);
    chk("single_valid_k1", m_valid, 0);
    step(1);
    chk("single_valid_k2", m_valid, 1);
    chk("single_data_k2", m_data, 32'hA5A5_0001);
    chk("single_fill_k2", fill, 1);
    step(1);
    chk("single_fill_k3", fill, 0);
    chk("single_valid_k3", m_valid, 0);

    // Fill to full capacity, then stall for five cycles
    do_reset();
    m_ready = 1'b0;
    for (int i = 0; i < CAP; i++) begin
      s_valid = 1'b1;
      s_data  = 100 + i;
      step(1);
    end
    chk("full_s_ready", s_ready, 0);
    chk("full_fill", fill, CAP);
    s_data = 999;
    step(5);
    s_valid = 1'b0;
`ifdef BRAM_FIFO_STATS_EN
    chk("full_stall5", stall_cnt, 5);
`else
    chk("full_stall_off", stall_cnt, 0);
`endif
    chk("full_fill_after_stall", fill, CAP);
    chk("full_head", m_data, 100);
    m_ready = 1'b1;
    step(25);
    chk("full_drained", fill, 0);
    chk("model_drained", q.size(), 0);

    // Streaming 100 words in and out with both sides always ready
    do_reset();
    m_ready = 1'b1;
    base    = pop_total;
    for (int i = 0; i < 100; i++) begin
      s_valid = 1'b1;
      s_data  = i;
      step(1);
    end
    s_valid = 1'b0;
    step(2);
    chk("stream_pops_e102", pop_total - base, 99);
    step(1);
    chk("stream_pops_e103", pop_total - base, 100);
    chk("stream_fill_end", fill, 0);

    // Reset while holding words with a read in flight
    do_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 11; i++) begin
      s_valid = 1'b1;
      s_data  = 200 + i;
      step(1);
    end
    s_valid = 1'b0;
    step(2);
    m_ready = 1'b1;
    step(1);
    m_ready = 1'b0;
    chk("midrst_fill_before", fill, 10);
    rst = 1'b1;
    #1;
    chk("midrst_m_valid", m_valid, 0);
    chk("midrst_fill", fill, 0);
    chk("midrst_s_ready", s_ready, 0);
    step(2);
    rst = 1'b0;
    step(1);
    chk("midrst_ready_back", s_ready, 1);
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_data  = 32'hBEEF_0000;
    step(1);
    s_valid = 1'b0;
    step(2);
    chk("midrst_new_valid", m_valid, 1);
    chk("midrst_new_data", m_data, 32'hBEEF_0000);
    step(1);
    chk("midrst_new_fill", fill, 0);

    // Randomized traffic in phases of different pressure
    do_reset();
    for (int ph = 0; ph < 8; ph++) begin
      for (int c = 0; c < 300; c++) begin
        s_valid = ($urandom_range(0, 99) < pv_tbl[ph]);
        s_data  = $urandom;
        m_ready = ($urandom_range(0, 99) < pr_tbl[ph]);
        step(1);
      end
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    step(30);
    chk("random_drained", fill, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
